// File: rtl/otter_mem_responder_if.sv
// Request/response bundle between an OTTER-style core and its memory responder.
// The core drives requests through the master modport; the responder uses slave.
interface otter_mem_responder_if;
    logic        MEM_READ1;
    logic [31:0] MEM_ADDR1;
    logic        MEM_READ2;
    logic        MEM_WRITE2;
    logic [31:0] MEM_ADDR2;
    logic [31:0] MEM_DIN2;
    logic [1:0]  MEM_SIZE;
    logic        MEM_SIGN;
    logic [31:0] MEM_DOUT1;
    logic [31:0] MEM_DOUT2;
    logic        MEM_VALID1;
    logic        MEM_VALID2;
    logic        MEM_ERR;

    modport master (
        output MEM_READ1, MEM_ADDR1, MEM_READ2, MEM_WRITE2, MEM_ADDR2,
        output MEM_DIN2, MEM_SIZE, MEM_SIGN,
        input  MEM_DOUT1, MEM_DOUT2, MEM_VALID1, MEM_VALID2, MEM_ERR
    );

    modport slave (
        input  MEM_READ1, MEM_ADDR1, MEM_READ2, MEM_WRITE2, MEM_ADDR2,
        input  MEM_DIN2, MEM_SIZE, MEM_SIGN,
        output MEM_DOUT1, MEM_DOUT2, MEM_VALID1, MEM_VALID2, MEM_ERR
    );
endinterface

// File: rtl/otter_mem_responder.sv
// Dual-port (fetch + load/store) word memory with fixed request-to-valid latency.
// Define OTTER_MEM_WAIT_EN to honour LATENCY; otherwise every access takes one cycle.
module otter_mem_responder #(
    parameter int LATENCY     = 4,
    parameter int DEPTH_WORDS = 16384
) (
    input  logic                 MEM_CLK,
    input  logic                 MEM_RESET,
    otter_mem_responder_if.slave bus
);
`ifdef OTTER_MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif
    localparam int         LAT_CLAMP   = (LATENCY < 1) ? 1 : ((LATENCY > 15) ? 15 : LATENCY);
    localparam int         EFF_LATENCY = WAIT_EN ? LAT_CLAMP : 1;
    localparam logic [3:0] CNT_LOAD    = 4'(EFF_LATENCY - 1);
    localparam int         AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_cnt;
    logic        r_port2;
    logic        r_write;
    logic        r_sign;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_din;
    logic        r_valid1;
    logic        r_valid2;
    logic        r_err;
    logic [31:0] r_dout1;
    logic [31:0] r_dout2;
    logic [31:0] r_mem [0:DEPTH_WORDS-1];

    logic        w_any_req;
    logic        w_latch;
    logic        w_enter_resp;
    logic        w_in_port2;
    logic [31:0] w_in_addr;
    logic [1:0]  w_in_size;
    logic        w_in_sign;
    logic        w_acc_port2;
    logic        w_acc_write;
    logic        w_acc_sign;
    logic [1:0]  w_acc_size;
    logic [31:0] w_acc_addr;
    logic [31:0] w_acc_din;
    logic        w_misalign;
    logic        w_oor;
    logic        w_err;
    logic [AW-1:0] w_idx;
    logic [1:0]  w_lane;
    logic [31:0] w_rword;
    logic [31:0] w_shift;
    logic [31:0] w_load;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;

    assign w_any_req  = bus.MEM_READ1 | bus.MEM_READ2 | bus.MEM_WRITE2;
    assign w_in_port2 = bus.MEM_WRITE2 | bus.MEM_READ2;
    assign w_in_addr  = w_in_port2 ? bus.MEM_ADDR2 : bus.MEM_ADDR1;
    assign w_in_size  = w_in_port2 ? bus.MEM_SIZE : 2'd2;
    assign w_in_sign  = w_in_port2 & bus.MEM_SIGN;

    // State register
    always_ff @(posedge MEM_CLK) begin
        if (MEM_RESET) r_state <= S_IDLE;
        else           r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_state_next = (EFF_LATENCY == 1) ? S_RESP : S_WAIT;
            S_WAIT:  if (r_cnt == 4'd1) w_state_next = S_RESP;
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM control outputs
    always_comb begin
        w_latch      = (r_state == S_IDLE) && w_any_req;
        w_enter_resp = (w_state_next == S_RESP);
    end

    // With single-cycle latency the access happens on the same edge that latches it,
    // so the live request is used instead of the not-yet-loaded registers.
    assign w_acc_port2 = w_latch ? w_in_port2     : r_port2;
    assign w_acc_write = w_latch ? bus.MEM_WRITE2 : r_write;
    assign w_acc_sign  = w_latch ? w_in_sign      : r_sign;
    assign w_acc_size  = w_latch ? w_in_size      : r_size;
    assign w_acc_addr  = w_latch ? w_in_addr      : r_addr;
    assign w_acc_din   = w_latch ? bus.MEM_DIN2   : r_din;

    assign w_misalign = (w_acc_size == 2'd3)
                      | ((w_acc_size == 2'd1) & w_acc_addr[0])
                      | ((w_acc_size == 2'd2) & (w_acc_addr[1:0] != 2'd0));
    assign w_oor      = (w_acc_addr[31:2] >= 30'(DEPTH_WORDS));
    assign w_err      = w_misalign | w_oor;
    assign w_idx      = w_acc_addr[AW+1:2];
    assign w_lane     = w_acc_addr[1:0];
    assign w_rword    = r_mem[w_idx];
    assign w_shift    = w_rword >> {w_lane, 3'b000};

    always_comb begin
        w_load = w_shift;
        case (w_acc_size)
            2'd0:    w_load = {{24{w_acc_sign & w_shift[7]}}, w_shift[7:0]};
            2'd1:    w_load = {{16{w_acc_sign & w_shift[15]}}, w_shift[15:0]};
            default: w_load = w_shift;
        endcase
    end

    // Per-lane byte enable and store data steering
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign w_be[gi] = (w_acc_size == 2'd0) ? (w_lane == LANE) :
                              (w_acc_size == 2'd1) ? (w_lane[1] == LANE[1]) : 1'b1;
            assign w_wdata[8*gi +: 8] = (w_acc_size == 2'd0) ? w_acc_din[7:0] :
                                        (w_acc_size == 2'd1) ? w_acc_din[8*(gi%2) +: 8] :
                                                               w_acc_din[8*gi +: 8];
        end
    endgenerate

    // Array is never reset so its contents survive MEM_RESET
    always_ff @(posedge MEM_CLK) begin
        if (!MEM_RESET && w_enter_resp && w_acc_write && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge MEM_CLK) begin
        if (MEM_RESET) begin
            r_cnt    <= 4'd0;
            r_port2  <= 1'b0;
            r_write  <= 1'b0;
            r_sign   <= 1'b0;
            r_size   <= 2'd0;
            r_addr   <= 32'd0;
            r_din    <= 32'd0;
            r_valid1 <= 1'b0;
            r_valid2 <= 1'b0;
            r_err    <= 1'b0;
            r_dout1  <= 32'd0;
            r_dout2  <= 32'd0;
        end else begin
            if (w_latch) begin
                r_cnt   <= CNT_LOAD;
                r_port2 <= w_in_port2;
                r_write <= bus.MEM_WRITE2;
                r_sign  <= w_in_sign;
                r_size  <= w_in_size;
                r_addr  <= w_in_addr;
                r_din   <= bus.MEM_DIN2;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            r_valid1 <= w_enter_resp & ~w_acc_port2;
            r_valid2 <= w_enter_resp & w_acc_port2;
            r_err    <= w_enter_resp & w_err;
            if (w_enter_resp) begin
                if (w_acc_port2) begin
                    if (w_err)             r_dout2 <= 32'd0;
                    else if (!w_acc_write) r_dout2 <= w_load;
                end else begin
                    r_dout1 <= w_err ? 32'd0 : w_load;
                end
            end
        end
    end

    assign bus.MEM_DOUT1  = r_dout1;
    assign bus.MEM_DOUT2  = r_dout2;
    assign bus.MEM_VALID1 = r_valid1;
    assign bus.MEM_VALID2 = r_valid2;
    assign bus.MEM_ERR    = r_err;
endmodule

// File: tb/tb_otter_mem_responder.sv
// Scoreboard bench for otter_mem_responder: byte-level reference memory, randomized
// fetch/load/store traffic, directed corner cases and a mid-access reset.
module tb_otter_mem_responder;
    localparam int LAT   = 4;
    localparam int DEPTH = 256;
`ifdef OTTER_MEM_WAIT_EN
    localparam int EXP_LAT = LAT;
`else
    localparam int EXP_LAT = 1;
`endif

    typedef struct {
        bit          port2;
        bit          chk_dout;
        logic [31:0] dout;
        bit          err;
        int          edge_no;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   edge_cnt = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    logic [31:0] mon_dout;
    bit   mon_ok;
    logic [7:0] ref_bytes [0:DEPTH*4-1];

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    otter_mem_responder_if bus();

    otter_mem_responder #(.LATENCY(LAT), .DEPTH_WORDS(DEPTH)) dut (
        .MEM_CLK  (clk),
        .MEM_RESET(rst),
        .bus      (bus)
    );

    function automatic bit acc_err(input logic [31:0] a, input logic [1:0] sz);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)
               || ((a / 4) >= 32'(DEPTH));
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input bit sg);
        int nb;
        logic [31:0] v;
        nb = 1 << sz;
        v  = 32'd0;
        for (int i = 0; i < nb; i++) v = v | (32'(ref_bytes[int'(a) + i]) << (8 * i));
        if (sg && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        for (int i = 0; i < (1 << sz); i++) ref_bytes[int'(a) + i] = d[8*i +: 8];
    endtask

    function automatic logic [31:0] rand_addr(input logic [1:0] sz);
        int r;
        logic [31:0] a;
        r = $urandom_range(0, 15);
        if (r == 0) return 32'(DEPTH * 4 + $urandom_range(0, 255));
        if (r == 1) return $urandom;
        a = 32'($urandom_range(0, DEPTH * 4 - 1));
        if (r < 12 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
        return a;
    endfunction

    task automatic clear_req();
        bus.MEM_READ1  = 1'b0;
        bus.MEM_READ2  = 1'b0;
        bus.MEM_WRITE2 = 1'b0;
    endtask

    // Drive one request set, push the expected responses in priority order, hold until served.
    task automatic issue(input bit rel, input bit r1, input logic [31:0] a1, input bit r2,
                         input bit w2, input logic [31:0] a2, input logic [31:0] din,
                         input logic [1:0] sz, input bit sg, input string nm);
        exp_t e;
        int   n0;
        int   k;
        k = 0;
        @(negedge clk);
        if (rel) rst = 1'b0;
        bus.MEM_READ1  = r1;
        bus.MEM_ADDR1  = a1;
        bus.MEM_READ2  = r2;
        bus.MEM_WRITE2 = w2;
        bus.MEM_ADDR2  = a2;
        bus.MEM_DIN2   = din;
        bus.MEM_SIZE   = sz;
        bus.MEM_SIGN   = sg;
        n0 = edge_cnt + 1;
        if (r2 || w2) begin
            e.port2   = 1'b1;
            e.err     = acc_err(a2, sz);
            e.edge_no = n0 + EXP_LAT - 1;
            e.name    = nm;
            if (w2) begin
                e.chk_dout = e.err;
                e.dout     = 32'd0;
                if (!e.err) ref_store(a2, sz, din);
            end else begin
                e.chk_dout = 1'b1;
                e.dout     = e.err ? 32'd0 : ref_load(a2, sz, sg);
            end
            sb_q.push_back(e);
            k = 1;
        end
        if (r1) begin
            e.port2    = 1'b0;
            e.err      = acc_err(a1, 2'd2);
            e.chk_dout = 1'b1;
            e.dout     = e.err ? 32'd0 : ref_load(a1, 2'd2, 1'b0);
            e.edge_no  = n0 + k * (EXP_LAT + 1) + EXP_LAT - 1;
            e.name     = {nm, "_p1"};
            sb_q.push_back(e);
        end
        for (int t = 0; t < 40 * EXP_LAT + 40 && (bus.MEM_READ1 || bus.MEM_READ2 || bus.MEM_WRITE2); t++) begin
            @(negedge clk);
            if (bus.MEM_VALID2) begin
                bus.MEM_READ2  = 1'b0;
                bus.MEM_WRITE2 = 1'b0;
            end
            if (bus.MEM_VALID1) bus.MEM_READ1 = 1'b0;
        end
        n_checks++;
        if (bus.MEM_READ1 || bus.MEM_READ2 || bus.MEM_WRITE2) begin
            n_fail++;
            $display("FAIL %s_timeout: request still pending after cycle budget, required a VALID", nm);
            clear_req();
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        n_checks++;
        if (bus.MEM_VALID1 || bus.MEM_VALID2 || bus.MEM_ERR || bus.MEM_DOUT1 != 32'd0 || bus.MEM_DOUT2 != 32'd0) begin
            n_fail++;
            $display("FAIL %s: V1=%0d V2=%0d ERR=%0d DOUT1=%08h DOUT2=%08h, required all zero",
                     nm, bus.MEM_VALID1, bus.MEM_VALID2, bus.MEM_ERR, bus.MEM_DOUT1, bus.MEM_DOUT2);
        end
    endtask

    // Monitor: every VALID pops one expectation
    always @(negedge clk) begin
        if (bus.MEM_VALID1 || bus.MEM_VALID2) begin
            n_checks++;
            if (bus.MEM_VALID1 && bus.MEM_VALID2) begin
                n_fail++;
                $display("FAIL both_valid: VALID1=1 VALID2=1 at edge %0d, required one at a time", edge_cnt);
            end else if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid: VALID1=%0d VALID2=%0d at edge %0d, required none",
                         bus.MEM_VALID1, bus.MEM_VALID2, edge_cnt);
            end else begin
                mon_e    = sb_q.pop_front();
                mon_dout = bus.MEM_VALID2 ? bus.MEM_DOUT2 : bus.MEM_DOUT1;
                mon_ok   = (bus.MEM_VALID2 == mon_e.port2) && (bus.MEM_ERR == mon_e.err)
                           && (edge_cnt == mon_e.edge_no) && (!mon_e.chk_dout || mon_dout == mon_e.dout);
                if (!mon_ok) begin
                    n_fail++;
                    $display("FAIL %s: got port2=%0d dout=%08h err=%0d edge=%0d, required port2=%0d dout=%08h(chk=%0d) err=%0d edge=%0d",
                             mon_e.name, bus.MEM_VALID2, mon_dout, bus.MEM_ERR, edge_cnt,
                             mon_e.port2, mon_e.dout, mon_e.chk_dout, mon_e.err, mon_e.edge_no);
                end else begin
                    $display("txn %-14s port%0d dout=%08h err=%0d edge=%0d",
                             mon_e.name, mon_e.port2 ? 2 : 1, mon_dout, bus.MEM_ERR, edge_cnt);
                end
            end
        end else if (bus.MEM_ERR) begin
            n_checks++;
            n_fail++;
            $display("FAIL err_without_valid: MEM_ERR=1 at edge %0d, required 0", edge_cnt);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before completion, required $finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int          op;
        logic [1:0]  sz;
        bit          sg;
        logic [31:0] a;
        logic [31:0] a1;
        clear_req();
        bus.MEM_ADDR1 = 32'd0;
        bus.MEM_ADDR2 = 32'd0;
        bus.MEM_DIN2  = 32'd0;
        bus.MEM_SIZE  = 2'd0;
        bus.MEM_SIGN  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_init");

        // Preload every word; the first store is sampled on the first edge out of reset
        for (int w = 0; w < DEPTH; w++)
            issue(w == 0, 1'b0, 32'd0, 1'b0, 1'b1, 32'(w * 4), $urandom, 2'd2, 1'b0, "preload");

        issue(0, 0, 0, 0, 1, 32'h10, 32'h00A00093, 2'd2, 0, "st_fetchword");
        issue(0, 1, 32'h10, 0, 0, 0, 0, 2'd0, 0, "fetch_0x10");
        issue(0, 0, 0, 0, 1, 32'h203, 32'h12345680, 2'd0, 0, "sb_0x203");
        issue(0, 0, 0, 1, 0, 32'h203, 0, 2'd0, 1, "lb_0x203");
        issue(0, 0, 0, 1, 0, 32'h203, 0, 2'd0, 0, "lbu_0x203");
        issue(0, 0, 0, 1, 0, 32'h200, 0, 2'd2, 0, "lw_0x200");
        issue(0, 0, 0, 1, 0, 32'h202, 0, 2'd1, 1, "lh_0x202");
        issue(0, 1, 32'h0, 0, 1, 32'h40, 32'hCAFEF00D, 2'd2, 0, "w2_vs_r1");
        issue(0, 1, 32'h40, 1, 0, 32'h41, 0, 2'd0, 1, "r2_vs_r1");
        issue(0, 0, 0, 1, 0, 32'h102, 0, 2'd2, 0, "lw_mis_0x102");
        issue(0, 0, 0, 0, 1, 32'h102, 32'h55AA55AA, 2'd2, 0, "sw_mis_0x102");
        issue(0, 0, 0, 1, 0, 32'h100, 0, 2'd2, 0, "lw_0x100");
        issue(0, 0, 0, 1, 0, 32'h104, 0, 2'd2, 0, "lw_0x104");
        issue(0, 0, 0, 1, 0, 32'h201, 0, 2'd1, 0, "lh_mis_0x201");
        issue(0, 0, 0, 1, 0, 32'h200, 0, 2'd3, 0, "size3");
        issue(0, 0, 0, 1, 0, 32'(DEPTH * 4), 0, 2'd2, 0, "lw_oor");
        issue(0, 1, 32'h402, 0, 0, 0, 0, 2'd0, 0, "fetch_mis");
        issue(0, 1, 32'(DEPTH * 4 - 4), 0, 0, 0, 0, 2'd0, 0, "fetch_last");

        // Reset two cycles into a store: aborted whenever latency leaves it unfinished
        @(negedge clk);
        bus.MEM_WRITE2 = 1'b1;
        bus.MEM_ADDR2  = 32'h300;
        bus.MEM_DIN2   = 32'hDEADBEEF;
        bus.MEM_SIZE   = 2'd2;
        if (EXP_LAT == 1) begin
            ref_store(32'h300, 2'd2, 32'hDEADBEEF);
            mon_e.port2 = 1'b1; mon_e.chk_dout = 1'b0; mon_e.dout = 32'd0; mon_e.err = 1'b0;
            mon_e.edge_no = edge_cnt + 1; mon_e.name = "st_before_rst";
            sb_q.push_back(mon_e);
        end
        @(negedge clk);
        rst = 1'b1;
        clear_req();
        @(negedge clk);
        check_reset_outputs("reset_abort");
        @(negedge clk);
        issue(1, 0, 0, 1, 0, 32'h300, 0, 2'd2, 0, "lw_after_rst");
        issue(0, 0, 0, 1, 0, 32'h10, 0, 2'd2, 0, "lw_kept_0x10");

        for (int t = 0; t < 300; t++) begin
            op = $urandom_range(0, 3);
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            a  = rand_addr(sz);
            a1 = rand_addr(2'd2);
            case (op)
                0:       issue(0, 1, a1, 0, 0, 0, 0, 2'd0, 0, "rnd_fetch");
                1:       issue(0, 0, 0, 1, 0, a, 0, sz, sg, "rnd_load");
                2:       issue(0, 0, 0, 0, 1, a, $urandom, sz, sg, "rnd_store");
                default: begin
                    if ($urandom_range(0, 1) == 0) issue(0, 1, a1, 1, 0, a, 0, sz, sg, "rnd_ld_fetch");
                    else                           issue(0, 1, a1, 0, 1, a, $urandom, sz, sg, "rnd_st_fetch");
                end
            endcase
        end

        repeat (5) @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
